// File: rtl/order_match_ctrl_pkg.sv
// Shared types and order-word layout for the order matching controller.
// Order word: [31] side (1 = buy), [30:16] price, [15:0] quantity.
package order_match_ctrl_pkg;

    localparam int ORD_PRICE_W   = 15;
    localparam int ORD_QTY_W     = 16;
    localparam int ORD_PRICE_LSB = 16;
    localparam int ORD_SIDE_BIT  = 31;

    // Heap command encoding shared with heap_manager.
    typedef enum logic [1:0] {
        CMD_NOP    = 2'd0,
        CMD_PUSH   = 2'd1,
        CMD_POP    = 2'd2,
        CMD_UPDATE = 2'd3
    } cmd_e;

    // Book identity: bids live in a max-heap, asks in a min-heap.
    typedef enum logic {
        TYPE_BID = 1'b0,
        TYPE_ASK = 1'b1
    } book_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT_DONE,
        S_SETTLE,
        S_FINISH
    } state_e;

    function automatic logic [31:0] mk_order(logic buy, logic [ORD_PRICE_W-1:0] price,
                                             logic [ORD_QTY_W-1:0] qty);
        return {buy, price, qty};
    endfunction

endpackage

// File: rtl/order_match_ctrl_if.sv
// Bundle of the ingress stream, both heap command/status buses and the trade output.
// master = matching controller, slave = surrounding environment (ingress, heaps, trade sink).
interface order_match_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_order;

    logic [1:0]  bid_cmd;
    logic [31:0] bid_data;
    logic [31:0] bid_root;
    logic        bid_empty;
    logic        bid_full;
    logic        bid_done;

    logic [1:0]  ask_cmd;
    logic [31:0] ask_data;
    logic [31:0] ask_root;
    logic        ask_empty;
    logic        ask_full;
    logic        ask_done;

    logic                                    trade_valid;
    logic [order_match_ctrl_pkg::ORD_PRICE_W-1:0] trade_price;
    logic [order_match_ctrl_pkg::ORD_QTY_W-1:0]   trade_qty;
    logic                                    trade_buy;
    logic                                    reject;

    modport master (
        input  in_valid, in_order,
        output in_ready,
        output bid_cmd, bid_data, ask_cmd, ask_data,
        input  bid_root, bid_empty, bid_full, bid_done,
        input  ask_root, ask_empty, ask_full, ask_done,
        output trade_valid, trade_price, trade_qty, trade_buy, reject
    );

    modport slave (
        output in_valid, in_order,
        input  in_ready,
        input  bid_cmd, bid_data, ask_cmd, ask_data,
        output bid_root, bid_empty, bid_full, bid_done,
        output ask_root, ask_empty, ask_full, ask_done,
        input  trade_valid, trade_price, trade_qty, trade_buy, reject
    );

endinterface

// File: rtl/order_cross_cmp.sv
// Combinational cross check of the current order against the opposite book's root.
// Produces the cross flag, the fill quantity min(cur, root) and both remainders.
module order_cross_cmp #(
    parameter int PRICE_W = 15,
    parameter int QTY_W   = 16
) (
    input  logic               i_buy,
    input  logic [PRICE_W-1:0] i_price,
    input  logic [QTY_W-1:0]   i_qty,
    input  logic [PRICE_W-1:0] i_root_price,
    input  logic [QTY_W-1:0]   i_root_qty,
    input  logic               i_opp_empty,
    output logic               o_cross,
    output logic               o_update,
    output logic [QTY_W-1:0]   o_fill_qty,
    output logic [QTY_W-1:0]   o_root_rem,
    output logic [QTY_W-1:0]   o_cur_rem
);

    // Equal prices cross; an empty opposite book never crosses.
    assign o_cross    = !i_opp_empty &&
                        (i_buy ? (i_price >= i_root_price) : (i_price <= i_root_price));
    // Resting order survives only when it is strictly larger than the aggressor.
    assign o_update   = i_root_qty > i_qty;
    assign o_fill_qty = o_update ? i_qty : i_root_qty;
    // Both subtractions are bounded by the min above, so neither underflows.
    assign o_root_rem = i_root_qty - o_fill_qty;
    assign o_cur_rem  = i_qty - o_fill_qty;

endmodule

// File: rtl/order_match_ctrl.sv
// Order matching sequencer: matches one order at a time against the opposite heap,
// consuming resting liquidity with POP/UPDATE and resting any remainder with PUSH.
// Optional build macro ORDER_CTRL_STATS_EN adds saturating trade/reject counters.
module order_match_ctrl
    import order_match_ctrl_pkg::*;
#(
    parameter int PRICE_W = ORD_PRICE_W,
    parameter int QTY_W   = ORD_QTY_W
) (
    input  logic               clk,
    input  logic               rst_n,
    order_match_ctrl_if.master bus
`ifdef ORDER_CTRL_STATS_EN
    ,
    output logic [31:0]        trade_count,
    output logic [15:0]        reject_count
`endif
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [31:0]        r_cur;
    cmd_e               r_cmd;
    logic               r_tgt_ask;
    logic [31:0]        r_data;
    logic               r_in_ready;
    logic               r_trade_valid;
    logic [PRICE_W-1:0] r_trade_price;
    logic [QTY_W-1:0]   r_trade_qty;
    logic               r_trade_buy;
    logic               r_reject;

    logic               w_accept;
    logic               w_enter_check;
    logic [31:0]        w_ord;
    logic               w_buy;
    logic [31:0]        w_opp_root;
    logic               w_opp_empty;
    logic               w_same_full;
    logic               w_tgt_done;
    logic               w_cross;
    logic               w_update;
    logic [QTY_W-1:0]   w_fill;
    logic [QTY_W-1:0]   w_root_rem;
    logic [QTY_W-1:0]   w_cur_rem;

    // In IDLE the comparator looks at the incoming word so the trade/reject decision
    // can be registered on the edge that enters CHECK; elsewhere it looks at cur.
    assign w_ord       = (r_state == S_IDLE) ? bus.in_order : r_cur;
    assign w_buy       = w_ord[ORD_SIDE_BIT];
    assign w_opp_root  = w_buy ? bus.ask_root  : bus.bid_root;
    assign w_opp_empty = w_buy ? bus.ask_empty : bus.bid_empty;
    assign w_same_full = w_buy ? bus.bid_full  : bus.ask_full;
    assign w_tgt_done  = r_tgt_ask ? bus.ask_done : bus.bid_done;

    order_cross_cmp #(
        .PRICE_W (PRICE_W),
        .QTY_W   (QTY_W)
    ) u_cmp (
        .i_buy        (w_buy),
        .i_price      (w_ord[ORD_PRICE_LSB +: PRICE_W]),
        .i_qty        (w_ord[QTY_W-1:0]),
        .i_root_price (w_opp_root[ORD_PRICE_LSB +: PRICE_W]),
        .i_root_qty   (w_opp_root[QTY_W-1:0]),
        .i_opp_empty  (w_opp_empty),
        .o_cross      (w_cross),
        .o_update     (w_update),
        .o_fill_qty   (w_fill),
        .o_root_rem   (w_root_rem),
        .o_cur_rem    (w_cur_rem)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; zero-quantity orders are swallowed without leaving IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid && r_in_ready) begin
                    w_accept = 1'b1;
                    if (w_ord[QTY_W-1:0] != '0) w_state_nxt = S_CHECK;
                end
            end
            S_CHECK:     w_state_nxt = (w_cross || !w_same_full) ? S_ISSUE : S_FINISH;
            S_ISSUE:     w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (w_tgt_done) w_state_nxt = S_SETTLE;
            S_SETTLE:    w_state_nxt = (r_cmd == CMD_POP && r_cur[QTY_W-1:0] != '0) ?
                                       S_CHECK : S_FINISH;
            S_FINISH:    w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    assign w_enter_check = (w_state_nxt == S_CHECK) && (r_state != S_CHECK);

    // Order latch, command scheduling and registered trade/reject/ready outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur         <= '0;
            r_cmd         <= CMD_NOP;
            r_tgt_ask     <= 1'b0;
            r_data        <= '0;
            r_in_ready    <= 1'b0;
            r_trade_valid <= 1'b0;
            r_trade_price <= '0;
            r_trade_qty   <= '0;
            r_trade_buy   <= 1'b0;
            r_reject      <= 1'b0;
        end else begin
            r_in_ready    <= (w_state_nxt == S_IDLE);
            r_trade_valid <= w_enter_check && w_cross;
            r_reject      <= w_enter_check && !w_cross && w_same_full;
            if (w_enter_check && w_cross) begin
                r_trade_price <= w_opp_root[ORD_PRICE_LSB +: PRICE_W];
                r_trade_qty   <= w_fill;
                r_trade_buy   <= w_buy;
            end
            if (w_accept) r_cur <= bus.in_order;
            if (r_state == S_CHECK) begin
                if (w_cross) begin
                    r_tgt_ask          <= w_buy;
                    r_cur[QTY_W-1:0]   <= w_cur_rem;
                    if (w_update) begin
                        r_cmd  <= CMD_UPDATE;
                        r_data <= {w_opp_root[31:QTY_W], w_root_rem};
                    end else begin
                        r_cmd  <= CMD_POP;
                        r_data <= '0;
                    end
                end else begin
                    r_cmd     <= CMD_PUSH;
                    r_tgt_ask <= !w_buy;
                    r_data    <= r_cur;
                end
            end
        end
    end

    // Commands are live only during ISSUE and only on the scheduled heap.
    assign bus.bid_cmd     = (r_state == S_ISSUE && !r_tgt_ask) ? r_cmd  : CMD_NOP;
    assign bus.ask_cmd     = (r_state == S_ISSUE &&  r_tgt_ask) ? r_cmd  : CMD_NOP;
    assign bus.bid_data    = (r_state == S_ISSUE && !r_tgt_ask) ? r_data : '0;
    assign bus.ask_data    = (r_state == S_ISSUE &&  r_tgt_ask) ? r_data : '0;
    assign bus.in_ready    = r_in_ready;
    assign bus.trade_valid = r_trade_valid;
    assign bus.trade_price = r_trade_price;
    assign bus.trade_qty   = r_trade_qty;
    assign bus.trade_buy   = r_trade_buy;
    assign bus.reject      = r_reject;

`ifdef ORDER_CTRL_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trade_count  <= '0;
            reject_count <= '0;
        end else begin
            if (r_trade_valid && trade_count  != '1) trade_count  <= trade_count  + 32'd1;
            if (r_reject      && reject_count != '1) reject_count <= reject_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_order_match_ctrl.sv
// Bench for order_match_ctrl: behavioural heaps with random latency, a plain-arithmetic
// order-book reference model, and a trade/reject scoreboard checked by a monitor.
module tb_order_match_ctrl;
    import order_match_ctrl_pkg::*;

    localparam int CAP = 1023;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    order_match_ctrl_if bus();
`ifdef ORDER_CTRL_STATS_EN
    logic [31:0] trade_count;
    logic [15:0] reject_count;
`endif

    order_match_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ORDER_CTRL_STATS_EN
        ,
        .trade_count  (trade_count),
        .reject_count (reject_count)
`endif
    );

    typedef struct {
        bit          rej;
        logic [14:0] p;
        logic [15:0] q;
        bit          b;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk = 0, n_fail = 0;
    int  exp_trades = 0, exp_rejects = 0;
    int  lat_max = 4;

    // index 0 = bid book, 1 = ask book; hb = heap model (driven by DUT), rb = reference
    logic [31:0] hb [2][CAP];
    logic [31:0] rb [2][CAP];
    int          hn [2] = '{0, 0};
    int          rn [2] = '{0, 0};
    bit          pend [2] = '{0, 0};
    int          cnt [2];
    logic [1:0]  pcmd [2];
    logic [31:0] pdata [2];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit better(int s, logic [31:0] a, logic [31:0] b);
        return (s == 0) ? (a[30:16] > b[30:16]) : (a[30:16] < b[30:16]);
    endfunction

    // Price priority, then arrival order among equal prices.
    function automatic void bk_ins(bit m, int s, logic [31:0] w);
        int i, n;
        n = m ? rn[s] : hn[s];
        if (n >= CAP) return;
        i = 0;
        while (i < n && !better(s, w, m ? rb[s][i] : hb[s][i])) i++;
        for (int j = n; j > i; j--) begin
            if (m) rb[s][j] = rb[s][j-1];
            else   hb[s][j] = hb[s][j-1];
        end
        if (m) begin rb[s][i] = w; rn[s]++; end
        else   begin hb[s][i] = w; hn[s]++; end
    endfunction

    function automatic void bk_pop(bit m, int s);
        int n;
        n = m ? rn[s] : hn[s];
        if (n == 0) return;
        for (int j = 0; j < n - 1; j++) begin
            if (m) rb[s][j] = rb[s][j+1];
            else   hb[s][j] = hb[s][j+1];
        end
        if (m) rn[s]--; else hn[s]--;
    endfunction

    // Reference: sweep the opposite book while prices cross, then rest or reject.
    function automatic void ref_order(logic [31:0] w);
        bit          b;
        int          so, ss;
        logic [15:0] q, f;
        logic [31:0] r;
        ev_t         e;
        b  = w[31];
        ss = b ? 0 : 1;
        so = b ? 1 : 0;
        q  = w[15:0];
        if (q == 0) return;
        while (q != 0 && rn[so] != 0) begin
            r = rb[so][0];
            if (b ? (w[30:16] < r[30:16]) : (w[30:16] > r[30:16])) break;
            f = (q < r[15:0]) ? q : r[15:0];
            e.rej = 0; e.p = r[30:16]; e.q = f; e.b = b;
            exp_q.push_back(e);
            exp_trades++;
            if (r[15:0] > f) rb[so][0][15:0] = r[15:0] - f;
            else             bk_pop(1, so);
            q = q - f;
        end
        if (q != 0) begin
            if (rn[ss] >= CAP) begin
                e.rej = 1; e.p = 0; e.q = 0; e.b = b;
                exp_q.push_back(e);
                exp_rejects++;
            end else begin
                bk_ins(1, ss, {w[31:16], q});
            end
        end
    endfunction

    // Behavioural heaps: accept a command, finish it after a random latency with a done pulse.
    initial begin : heaps
        logic [1:0] c;
        logic       dn;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int s = 0; s < 2; s++) begin
                c  = (s == 0) ? bus.bid_cmd : bus.ask_cmd;
                dn = 1'b0;
                if (!rst_n) begin
                    pend[s] = 0;
                    hn[s]   = 0;
                end else if (pend[s]) begin
                    cnt[s]--;
                    if (cnt[s] == 0) begin
                        case (pcmd[s])
                            2'd1:    bk_ins(0, s, pdata[s]);
                            2'd2:    bk_pop(0, s);
                            2'd3:    if (hn[s] != 0) hb[s][0] = pdata[s];
                            default: ;
                        endcase
                        pend[s] = 0;
                        dn      = 1'b1;
                    end
                end else if (c != 2'd0) begin
                    pend[s]  = 1;
                    cnt[s]   = $urandom_range(1, lat_max);
                    pcmd[s]  = c;
                    pdata[s] = (s == 0) ? bus.bid_data : bus.ask_data;
                end
                if (s == 0) begin
                    bus.bid_done  <= dn;
                    bus.bid_root  <= (hn[0] != 0) ? hb[0][0] : 32'd0;
                    bus.bid_empty <= (hn[0] == 0);
                    bus.bid_full  <= (hn[0] >= CAP);
                end else begin
                    bus.ask_done  <= dn;
                    bus.ask_root  <= (hn[1] != 0) ? hb[1][0] : 32'd0;
                    bus.ask_empty <= (hn[1] == 0);
                    bus.ask_full  <= (hn[1] >= CAP);
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every trade/reject pulse and polices command issue.
    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.trade_valid || bus.reject) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_event: trade=%0b reject=%0b price=%0d qty=%0d",
                                 bus.trade_valid, bus.reject, bus.trade_price, bus.trade_qty);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_is_reject", 64'(bus.reject), 64'(e.rej));
                        if (!e.rej) begin
                            chk("trade_price", 64'(bus.trade_price), 64'(e.p));
                            chk("trade_qty",   64'(bus.trade_qty),   64'(e.q));
                            chk("trade_buy",   64'(bus.trade_buy),   64'(e.b));
                        end
                    end
                end
                if (bus.bid_cmd != 2'd0 || bus.ask_cmd != 2'd0) begin
                    chk("cmd_on_one_heap", 64'(bus.bid_cmd != 2'd0 && bus.ask_cmd != 2'd0), 64'd0);
                    chk("cmd_heap_idle",
                        64'((bus.bid_cmd != 2'd0 && (pend[0] || bus.bid_done)) ||
                            (bus.ask_cmd != 2'd0 && (pend[1] || bus.ask_done))), 64'd0);
                end
            end
        end
    end

    task automatic cmp_books();
        bit same;
        for (int s = 0; s < 2; s++) begin
            chk(s == 0 ? "bid_book_size" : "ask_book_size", 64'(hn[s]), 64'(rn[s]));
            same = (hn[s] == rn[s]);
            for (int i = 0; i < rn[s] && same; i++) if (hb[s][i] !== rb[s][i]) same = 0;
            chk(s == 0 ? "bid_book_content" : "ask_book_content", 64'(same), 64'd1);
        end
        chk("events_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic send(logic [31:0] w);
        int n;
        ref_order(w);
        n = 0;
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        bus.in_order = w;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 3000) begin @(negedge clk); n++; end
        n_chk++;
        if (!bus.in_ready) begin
            n_fail++;
            $display("FAIL order_done_timeout: in_ready=%0b required 1 (order %08h)", bus.in_ready, w);
        end
        cmp_books();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("outputs_zero_in_reset",
            64'(|{bus.in_ready, bus.bid_cmd, bus.ask_cmd, bus.bid_data, bus.ask_data,
                  bus.trade_valid, bus.trade_price, bus.trade_qty, bus.trade_buy, bus.reject}),
            64'd0);
        rn[0] = 0; rn[1] = 0;
        exp_q.delete();
        exp_trades = 0; exp_rejects = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
`ifdef ORDER_CTRL_STATS_EN
        chk("trade_count_reset",  64'(trade_count),  64'd0);
        chk("reject_count_reset", 64'(reject_count), 64'd0);
`endif
    endtask

    initial begin : watchdog
        #900000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin : stim
        int n;
        bus.in_valid = 1'b0;
        bus.in_order = '0;
        do_reset();

        // Empty books: buy rests on the bid heap.
        send(mk_order(1'b1, 15'd100, 16'd10));
        chk("c1_bid_root", 64'(bus.bid_root), 64'(mk_order(1'b1, 15'd100, 16'd10)));

        // Partial fill of a resting ask -> UPDATE leaves 6.
        do_reset();
        send(mk_order(1'b0, 15'd100, 16'd10));
        send(mk_order(1'b1, 15'd105, 16'd4));
        chk("c2_ask_root", 64'(bus.ask_root), 64'(mk_order(1'b0, 15'd100, 16'd6)));

        // Two-level sweep, book empties, remainder rests.
        do_reset();
        send(mk_order(1'b0, 15'd100, 16'd3));
        send(mk_order(1'b0, 15'd101, 16'd3));
        send(mk_order(1'b1, 15'd101, 16'd10));
        chk("c3_ask_empty", 64'(bus.ask_empty), 64'd1);
        chk("c3_bid_root",  64'(bus.bid_root), 64'(mk_order(1'b1, 15'd101, 16'd4)));

        // Equal-price exact fill: POP, no PUSH.
        do_reset();
        send(mk_order(1'b1, 15'd99, 16'd5));
        send(mk_order(1'b0, 15'd99, 16'd5));
        chk("c4_bid_empty", 64'(bus.bid_empty), 64'd1);
        chk("c4_ask_empty", 64'(bus.ask_empty), 64'd1);

        // Full bid book: non-crossing buy is rejected.
        do_reset();
        for (int i = 0; i < CAP; i++) begin
            hb[0][i] = mk_order(1'b1, 15'd10, 16'd1);
            rb[0][i] = hb[0][i];
        end
        hn[0] = CAP; rn[0] = CAP;
        @(negedge clk); @(negedge clk);
        send(mk_order(1'b1, 15'd50, 16'd1));
        chk("c5_bid_count", 64'(hn[0]), 64'(CAP));
`ifdef ORDER_CTRL_STATS_EN
        chk("c5_reject_count", 64'(reject_count), 64'd1);
`endif

        // Reset while waiting on a POP.
        do_reset();
        send(mk_order(1'b1, 15'd99, 16'd5));
        lat_max = 20;
        ref_order(mk_order(1'b0, 15'd99, 16'd5));
        bus.in_order = mk_order(1'b0, 15'd99, 16'd5);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(pend[0] && bus.bid_cmd == 2'd0) && n < 100);
        chk("c6_reached_wait_done", 64'(pend[0]), 64'd1);
        do_reset();
        lat_max = 4;
        cmp_books();

        // Random order flow around a narrow price band.
        do_reset();
        for (int k = 0; k < 80; k++) begin
            logic [15:0] q;
            q = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
            send(mk_order(1'($urandom_range(0, 1)), 15'($urandom_range(95, 105)), q));
        end
`ifdef ORDER_CTRL_STATS_EN
        @(negedge clk);
        chk("trade_count",  64'(trade_count),  64'(exp_trades));
        chk("reject_count", 64'(reject_count), 64'(exp_rejects));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/order_match_ctrl.md
# order_match_ctrl

Sequencer that sits between the order ingress stream and the two `heap_manager` instances (bid max-heap, ask min-heap). It accepts one order at a time and matches it against the opposite book's best price, emitting trades. It drives POP/UPDATE commands to consume resting liquidity, then PUSHes any unfilled remainder onto the same-side book. It is the sole command master of both heaps.

## Interface
- `PRICE_W`, default 15: price field width, bits [30:16] of an order word.
- `QTY_W`, default 16: quantity field width, bits [15:0]; bit 31 is the side, 1 = buy.
- One clock; reset is asynchronous and active-low.
- `clk` in 1: system clock.
- `rst_n` in 1: async active-low reset.
- `in_valid` in 1: incoming order valid.
- `in_ready` out 1: controller can accept an order.
- `in_order` in 32: order word.
- `bid_cmd` / `ask_cmd` out 2: heap commands: NOP=0, PUSH=1, POP=2, UPDATE=3.
- `bid_data` / `ask_data` out 32: heap data_in.
- `bid_root` / `ask_root` in 32: heap best element.
- `bid_empty`, `bid_full`, `bid_done` / `ask_*` in 1: heap status.
- `trade_valid` out 1: one-cycle trade pulse.
- `trade_price` out PRICE_W: resting order's price.
- `trade_qty` out QTY_W: filled quantity.
- `trade_buy` out 1: aggressor side, 1 = buy.
- `reject` out 1: one-cycle pulse when a remainder cannot rest because the same-side book is full.

## Operation
- States: IDLE, CHECK, ISSUE, WAIT_DONE, SETTLE, FINISH.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch the order into `cur` and go to CHECK.
  - An order with qty 0 is consumed and dropped with no other action; stay in IDLE.
- **CHECK** uses the opposite book `opp`:
  - Cross condition: buy price >= ask_root price, or sell price <= bid_root price, with `opp` non-empty.
  - On cross:
    - Pulse a trade with qty = min(cur.qty, root.qty).
    - root.qty > cur.qty: schedule UPDATE with the root word, qty = root.qty − cur.qty; then cur.qty = 0.
    - Otherwise: schedule POP; cur.qty −= root.qty.
  - No cross, cur.qty > 0, same-side book not full: schedule PUSH of `cur`.
  - No cross, same-side book full: pulse `reject` and go to FINISH.
- **ISSUE**: drive the scheduled command on exactly one heap for exactly one cycle; all other cmd outputs are NOP.
- **WAIT_DONE**: hold NOP until the target heap's `done`, then go to SETTLE.
- **SETTLE**: one cycle so that root/empty reflect the completed operation.
  - After a POP with cur.qty > 0: go to CHECK.
  - Otherwise: go to FINISH.
- **FINISH**: go to IDLE.
- Arithmetic: quantity subtraction is unsigned QTY_W and never underflows, because min() guards it. Price compares are unsigned.
- Boundary conditions:
  - Equal prices cross.
  - Exact fill POPs the root and does not PUSH.
  - When the opposite book empties mid-sweep, the remainder rests.
- Reset mid-operation: the FSM returns to IDLE. Both heaps share `rst_n`, so no partial command survives.

## Timing
- Reset values: `in_ready`=0 during reset and 1 in the first cycle after; every other output, including cmd=NOP and data, is 0.
- Acceptance to CHECK: 1 cycle.
- A trade pulse occurs in the CHECK cycle; its data is registered on the same cycle as `trade_valid`.
- A cmd is never issued while the target heap's `busy` or `done` is high.
- Each consumed resting order costs ISSUE + heap latency + 2 cycles.
- `in_ready` is low from acceptance until IDLE is re-entered. `in_valid` held during that time is not consumed.

## Configuration
- `ORDER_CTRL_STATS_EN` defined: adds outputs `trade_count` (32 bits) and `reject_count` (16 bits).
  - Both reset to 0.
  - Each increments on its pulse and saturates at all-ones.
- `ORDER_CTRL_STATS_EN` undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- `order_defines.v` holds:
  - field macros PRICE/QTY/SIDE;
  - CMD_NOP/PUSH/POP/UPDATE;
  - TYPE_BID/ASK;
  - the order word layout.
- One sub-module, `order_cross_cmp` (combinational): computes the cross flag, the min quantity and the root remainder from side, `cur` and `opp` root.

## Test plan
- Empty books, buy p=100 q=10 -> bid PUSH issued, no trade, bid_root=buy/100/10.
- Resting ask 100/10, buy 105/4 -> trade price 100 qty 4, ask UPDATE issued, ask_root qty=6, nothing pushed.
- Asks 100/3 and 101/3, buy 101/10 -> trades (100,3) then (101,3), two ask POPs, bid rests 101/4, ask_empty=1.
- Bid 99/5, sell 99/5 -> trade (99,5), bid POP, bid_empty=1, no PUSH.
- Bid book full (1023 entries), buy 50/1 with no cross -> `reject` pulse, bid count remains 1023.
- Assert `rst_n` during WAIT_DONE of a POP -> all outputs 0 while in reset, IDLE with `in_ready`=1 after release, stats counters (if enabled) =0.
